// File: rtl/boot_pkg.sv
// Shared types and constants for the boot sequencer and its byte packer.
package boot_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } boot_state_t;

  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned CSUM_W    = 8;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned IDX_W     = $clog2(HDR_BYTES);

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer; word_c is the assembled word on the
// cycle the 4th byte is presented, flagged by word_done_c.
module byte_packer
  import boot_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_c,
  output logic              word_done_c
);

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // New byte enters at the top so the first byte ends up in bits [7:0].
  always_comb begin
    word_c      = {byte_i, shift_q};
    word_done_c = en_i && (idx_q == IDX_W'(HDR_BYTES - 1));
    idx_d       = idx_q;
    shift_d     = shift_q;
    if (clr_i) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (en_i) begin
      idx_d   = idx_q + IDX_W'(1);
      shift_d = word_c[WORD_W-1:BYTE_W];
    end
  end

endmodule

// File: rtl/boot_ctrl.sv
// Boot sequencer: loads a counted, checksummed image into instruction memory
// over a byte stream, then releases the core from reset.
module boot_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int unsigned     MAX_WORDS = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rx_valid_i,
  input  logic [7:0]      rx_data_i,
  output logic            rx_ready_o,
  output logic            imem_we_o,
  output logic [XLEN-1:0] imem_addr_o,
  output logic [XLEN-1:0] imem_data_o,
  output logic            cpu_rst_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  boot_state_t       state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [XLEN-1:0]   imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]   imem_data_q, imem_data_d;
  logic [XLEN-1:0]   next_addr_q, next_addr_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CSUM_W-1:0] csum_q, csum_d;

  logic              xfer;
  logic              pack_en;
  logic              pack_clr;
  logic [WORD_W-1:0] word_c;
  logic              word_done_c;
  logic              last_word;

  assign xfer      = rx_valid_i & rx_ready_q;
  assign pack_en   = xfer && ((state_q == S_HDR) || (state_q == S_DATA));
  assign pack_clr  = (state_d != state_q);
  assign last_word = (word_cnt_q == (word_count_q - CNT_W'(1)));

  byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (pack_clr),
    .en_i        (pack_en),
    .byte_i      (rx_data_i),
    .word_c      (word_c),
    .word_done_c (word_done_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_HDR;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_data_q  <= '0;
      next_addr_q  <= BASE_ADDR;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
      word_cnt_q   <= '0;
      csum_q       <= '0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      next_addr_q  <= next_addr_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
      word_cnt_q   <= word_cnt_d;
      csum_q       <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR: begin
        if (word_done_c) begin
          if ((word_c == '0) || (word_c > WORD_W'(MAX_WORDS))) state_d = S_ERR;
          else                                                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_done_c && last_word) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (xfer) state_d = (rx_data_i == csum_q) ? S_RUN : S_ERR;
      end
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Output/datapath registers follow the next state so they change with it.
  always_comb begin
    rx_ready_d   = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    cpu_rst_d    = (state_d != S_RUN);
    done_d       = (state_d == S_RUN);
    err_d        = (state_d == S_ERR);
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    next_addr_d  = next_addr_q;
    word_count_d = word_count_q;
    word_cnt_d   = word_cnt_q;
    csum_d       = csum_q;

    if ((state_q == S_HDR) && word_done_c) begin
      word_count_d = CNT_W'(word_c);
    end

    if ((state_q == S_DATA) && xfer) begin
      csum_d = CSUM_W'(csum_q + rx_data_i);
    end

    if ((state_q == S_DATA) && word_done_c) begin
      imem_we_d   = 1'b1;
      imem_addr_d = next_addr_q;
      imem_data_d = XLEN'(word_c);
      next_addr_d = next_addr_q + XLEN'(4);
      word_cnt_d  = word_cnt_q + CNT_W'(1);
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_data_o = imem_data_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: nominal load, bad checksum/header, valid gaps
// and resets mid-word and while running.
module tb_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_o;
  logic        cpu_rst_o;
  logic        done_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];
  int          wr_cnt = 0;
  int          acc4    [2];

  logic [7:0]  img [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
  logic [7:0]  good_sum;

  boot_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_o (imem_data_o),
    .cpu_rst_o   (cpu_rst_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we_o && wr_cnt < 64) begin
      wr_addr[wr_cnt] = imem_addr_o;
      wr_data[wr_cnt] = imem_data_o;
      wr_cyc[wr_cnt]  = cyc;
      wr_cnt          = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rx_valid_i = 1'b0;
    rst_i      = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  // Idle for gap cycles, then offer one byte until it is taken; returns at
  // #1 after the accepting edge with that edge's cycle index.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    int n = 0;
    acc = -1;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk);
    while (!rx_ready_o && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready_o) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout: observed rx_ready_o=0 expected 1 within 16 cycles");
      rx_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc        = cyc;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  task automatic send_hdr(input logic [31:0] cnt, input int gap);
    int c;
    logic [31:0] w;
    w = cnt;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap, c);
  endtask

  task automatic send_image(input logic [7:0] csum, input int gap);
    int c;
    send_hdr(32'd2, gap);
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i], gap, c);
      if (i % 4 == 3) acc4[i / 4] = c;
    end
    check("pre_csum_cpu_rst", 32'(cpu_rst_o), 32'd1);
    send_byte(csum, gap, c);
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_wr_count"}, 32'(wr_cnt - base), 32'd2);
    check({tag, "_wr0_addr"}, wr_addr[base],     32'h0000_0000);
    check({tag, "_wr0_data"}, wr_data[base],     32'h0010_0513);
    check({tag, "_wr1_addr"}, wr_addr[base + 1], 32'h0000_0004);
    check({tag, "_wr1_data"}, wr_data[base + 1], 32'h0000_006F);
    check({tag, "_wr0_lat"},  32'(wr_cyc[base]),     32'(acc4[0]));
    check({tag, "_wr1_lat"},  32'(wr_cyc[base + 1]), 32'(acc4[1]));
  endtask

  initial begin
    int base;
    int c;
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    good_sum   = 8'h00;
    for (int i = 0; i < 8; i++) good_sum = good_sum + img[i];

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready",  32'(rx_ready_o), 32'd0);
    check("rst_we",        32'(imem_we_o),  32'd0);
    check("rst_addr",      imem_addr_o,     32'h0);
    check("rst_data",      imem_data_o,     32'h0);
    check("rst_cpu_rst",   32'(cpu_rst_o),  32'd1);
    check("rst_done",      32'(done_o),     32'd0);
    check("rst_err",       32'(err_o),      32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rx_ready", 32'(rx_ready_o), 32'd1);

    // Nominal back-to-back load
    base = wr_cnt;
    send_image(good_sum, 0);
    check("nom_cpu_rst",  32'(cpu_rst_o),  32'd0);
    check("nom_done",     32'(done_o),     32'd1);
    check("nom_err",      32'(err_o),      32'd0);
    check("nom_rx_ready", 32'(rx_ready_o), 32'd0);
    @(negedge clk);
    check_writes("nom", base);
    check("nom_hold_addr", imem_addr_o, 32'h4);
    check("nom_hold_data", imem_data_o, 32'h6F);

    // Reset while running
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("runrst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("runrst_done",    32'(done_o),    32'd0);
    check("runrst_we",      32'(imem_we_o), 32'd0);
    check("runrst_addr",    imem_addr_o,    32'h0);
    @(posedge clk);
    #1;
    check("runrst_rx_ready", 32'(rx_ready_o), 32'd1);

    // Bad checksum
    base = wr_cnt;
    send_image(good_sum - 8'd1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("badsum_err",      32'(err_o),        32'd1);
    check("badsum_cpu_rst",  32'(cpu_rst_o),    32'd1);
    check("badsum_done",     32'(done_o),       32'd0);
    check("badsum_rx_ready", 32'(rx_ready_o),   32'd0);
    check("badsum_wr_count", 32'(wr_cnt - base), 32'd2);

    // Bad header: zero count
    do_reset();
    base = wr_cnt;
    send_hdr(32'd0, 0);
    check("cnt0_err",      32'(err_o),      32'd1);
    check("cnt0_rx_ready", 32'(rx_ready_o), 32'd0);
    check("cnt0_cpu_rst",  32'(cpu_rst_o),  32'd1);

    // Bad header: MAX_WORDS+1
    do_reset();
    send_hdr(32'd1025, 0);
    check("cnt1025_err",      32'(err_o),      32'd1);
    check("cnt1025_rx_ready", 32'(rx_ready_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("badhdr_wr_count", 32'(wr_cnt - base), 32'd0);

    // Valid gaps of 3 cycles between every byte
    do_reset();
    base = wr_cnt;
    send_image(good_sum, 3);
    check("gap_done",    32'(done_o),    32'd1);
    check("gap_cpu_rst", 32'(cpu_rst_o), 32'd0);
    @(negedge clk);
    check_writes("gap", base);

    // Reset after two data bytes, then resend the whole image
    do_reset();
    base = wr_cnt;
    send_hdr(32'd2, 0);
    send_byte(8'h13, 0, c);
    send_byte(8'h05, 0, c);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("midrst_we", 32'(imem_we_o), 32'd0);
    send_image(good_sum, 0);
    check("midrst_done", 32'(done_o), 32'd1);
    check("midrst_err",  32'(err_o),  32'd0);
    @(negedge clk);
    check_writes("midrst", base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
